// File: rtl/alu_nzcv_if.sv
// Operand/opcode bus between decoder/register file and the NZCV ALU.
// The master drives the opcode and operands, and the slave returns the registered result and flags.
interface alu_nzcv_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       instruction;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output instruction, num1, num2,
    input  result, flags
  );

  modport slave (
    input  instruction, num1, num2,
    output result, flags
  );
endinterface

// File: rtl/alu_nzcv_core.sv
// Registered ALU with a single cycle of latency. It does logical and add/subtract-with-carry ops
// and keeps an NZCV flag register, with flags[0]=N, [1]=Z, [2]=C and [3]=V.
module alu_nzcv_core #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_nzcv_if.slave    bus
);

  localparam logic [4:0] OP_ANDS = 5'd1;
  localparam logic [4:0] OP_ORRS = 5'd2;
  localparam logic [4:0] OP_MVNS = 5'd3;
  localparam logic [4:0] OP_EORS = 5'd4;
  localparam logic [4:0] OP_NAND = 5'd5;
  localparam logic [4:0] OP_ADCS = 5'd6;
  localparam logic [4:0] OP_ADDS = 5'd7;
  localparam logic [4:0] OP_SBCS = 5'd8;
  localparam logic [4:0] OP_SUB  = 5'd9;
  localparam logic [4:0] OP_CMP  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd19;

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic [WIDTH-1:0] w_logic_res;
  logic             w_is_logic;
  logic             w_is_arith;
  logic             w_is_sub;
  logic             w_cin;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sum_res;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_nxt_result;
  logic [3:0]       w_nxt_flags;

  assign w_is_logic = (bus.instruction >= OP_ANDS) && (bus.instruction <= OP_NAND);
  assign w_is_arith = ((bus.instruction >= OP_ADCS) && (bus.instruction <= OP_SUB)) ||
                      (bus.instruction == OP_CMP);
  assign w_is_sub   = (bus.instruction == OP_SBCS) || (bus.instruction == OP_SUB) ||
                      (bus.instruction == OP_CMP);

  // Subtraction is A + ~B + cin, so C=1 means no borrow.
  assign w_b   = w_is_sub ? ~bus.num2 : bus.num2;
  assign w_cin = ((bus.instruction == OP_ADCS) || (bus.instruction == OP_SBCS)) ? r_flags[2] :
                 ((bus.instruction == OP_SUB)  || (bus.instruction == OP_CMP));

  assign w_sum     = {1'b0, bus.num1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_sum_res = w_sum[WIDTH-1:0];
  assign w_cout    = w_sum[WIDTH];
  assign w_ovf     = (bus.num1[WIDTH-1] == w_b[WIDTH-1]) &&
                     (w_sum_res[WIDTH-1] != bus.num1[WIDTH-1]);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_logic_res = '0;
    case (bus.instruction)
      OP_ANDS: w_logic_res = bus.num1 & bus.num2;
      OP_ORRS: w_logic_res = bus.num1 | bus.num2;
      OP_MVNS: w_logic_res = ~bus.num1;
      OP_EORS: w_logic_res = bus.num1 ^ bus.num2;
      OP_NAND: w_logic_res = ~(bus.num1 & bus.num2);
      default: w_logic_res = '0;
    endcase
  end

  always_comb begin
    w_nxt_result = r_result;
    w_nxt_flags  = r_flags;
    if (w_is_logic) begin
      w_nxt_result = w_logic_res;
      w_nxt_flags  = {r_flags[3], 1'b0, ~|w_logic_res, w_logic_res[WIDTH-1]};
    end else if (w_is_arith) begin
      if (bus.instruction != OP_CMP) w_nxt_result = w_sum_res;
      w_nxt_flags = {w_ovf, w_cout, ~|w_sum_res, w_sum_res[WIDTH-1]};
    end else if (bus.instruction != OP_NOP) begin
      // Undefined opcodes clear the result but leave the flags intact.
      w_nxt_result = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else begin
      r_result <= w_nxt_result;
      r_flags  <= w_nxt_flags;
    end
  end

  assign bus.result = r_result;
  assign bus.flags  = r_flags;

endmodule

// File: tb/tb_alu_nzcv_core.sv
// Self-checking bench for alu_nzcv_core. It applies directed vectors and reset corner cases,
// then random ops checked against a signed/unsigned integer reference model.
module tb_alu_nzcv_core;

  logic clk;
  logic rst_n;

  alu_nzcv_if #(.WIDTH(32)) bus ();

  alu_nzcv_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs [20];

  logic [31:0] m_res;
  logic [3:0]  m_flags;

  task automatic check(input string name, input logic [31:0] exp_res, input logic [3:0] exp_flg);
    n_tests++;
    if (bus.result !== exp_res || bus.flags !== exp_flg) begin
      n_fail++;
      $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
               name, bus.result, bus.flags, exp_res, exp_flg);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.instruction = op;
    bus.num1        = a;
    bus.num2        = b;
  endtask

  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    @(posedge clk);
    #1;
  endtask

  // The reference model works from integer arithmetic and signed range limits.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, s, u;
    logic   cin, c, v;
    logic [31:0] r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cin = m_flags[2];
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
        case (op)
          5'd1:    r = a & b;
          5'd2:    r = a | b;
          5'd3:    r = ~a;
          5'd4:    r = a ^ b;
          default: r = ~(a & b);
        endcase
        m_res   = r;
        m_flags = {m_flags[3], 1'b0, r == 32'd0, r[31]};
      end
      5'd6, 5'd7: begin
        if (op == 5'd7) cin = 1'b0;
        u = ua + ub + longint'(cin);
        s = sa + sb + longint'(cin);
        r = u[31:0];
        c = (u >= 64'sd4294967296);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        m_res   = r;
        m_flags = {v, c, r == 32'd0, r[31]};
      end
      5'd8, 5'd9, 5'd18: begin
        if (op != 5'd8) cin = 1'b1;
        u = ua - ub - longint'(!cin);
        s = sa - sb - longint'(!cin);
        r = u[31:0];
        c = (u >= 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (op != 5'd18) m_res = r;
        m_flags = {v, c, r == 32'd0, r[31]};
      end
      5'd19: ;
      default: m_res = 32'd0;
    endcase
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{5'd1,  32'hF0F0_F0F0, 32'h8F00_00FF, 32'h8000_00F0, 4'b0001};
    vecs[1]  = '{5'd1,  32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 4'b0010};
    vecs[2]  = '{5'd3,  32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 4'b0010};
    vecs[3]  = '{5'd3,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001};
    vecs[4]  = '{5'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
    vecs[5]  = '{5'd6,  32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 4'b0000};
    vecs[6]  = '{5'd7,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
    vecs[7]  = '{5'd4,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 4'b1000};
    vecs[8]  = '{5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1010};
    vecs[9]  = '{5'd9,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0001};
    vecs[10] = '{5'd9,  32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 4'b0100};
    vecs[11] = '{5'd18, 32'h0000_0003, 32'h0000_0003, 32'h0000_0002, 4'b0110};
    vecs[12] = '{5'd9,  32'h0000_1235, 32'h0000_0001, 32'h0000_1234, 4'b0100};
    vecs[13] = '{5'd19, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0000_1234, 4'b0100};
    vecs[14] = '{5'd0,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100};
    vecs[15] = '{5'd25, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100};
    vecs[16] = '{5'd8,  32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 4'b0100};
    vecs[17] = '{5'd2,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0010};
    vecs[18] = '{5'd8,  32'h0000_000A, 32'h0000_0003, 32'h0000_0006, 4'b0100};
    vecs[19] = '{5'd17, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0100};

    // Hold reset while the clock runs with a live ADDS on the bus.
    rst_n = 1'b0;
    drive(5'd7, 32'd5, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 32'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'd8, 4'b0000);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].res, vecs[i].flg);
    end

    // A mid-stream reset must clear outputs at once and clear C_old for the next ADCS.
    step(5'd7, 32'hFFFF_FFFF, 32'd1);
    check("pre_abort_carry", 32'd0, 4'b0110);
    drive(5'd7, 32'h1111_1111, 32'h2222_2222);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 32'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'd6, 32'd0, 32'd0);
    check("adcs_after_abort", 32'd0, 4'b0010);

    // Back-to-back carry chain with ADCS -> ADCS -> SBCS.
    step(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("chain_adds", 32'hFFFF_FFFE, 4'b0101);
    step(5'd6, 32'd0, 32'd0);
    check("chain_adcs", 32'd1, 4'b0000);
    step(5'd8, 32'd0, 32'd0);
    check("chain_sbcs", 32'hFFFF_FFFF, 4'b0001);

    // Random phase begins from a fresh reset so the model starts from known state.
    rst_n = 1'b0;
    #3;
    m_res   = 32'd0;
    m_flags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(6, 9));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'h7FFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = a;
        default: ;
      endcase
      step(op, a, b);
      model(op, a, b);
      check($sformatf("rand%0d_op%0d", i, op), m_res, m_flags);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
